// File: rtl/ask_rx_pkg.sv
// Shared state encoding, default geometry and parity helper for the ASK receive word assembler.
package ask_rx_pkg;

  localparam int WORD_W_DEF  = 12;
  localparam int GAP_CYC_DEF = 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } asm_state_t;

  function automatic logic odd_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/word_assembler_if.sv
// Serial bit input and assembled-word valid/ready output bundle.
interface word_assembler_if
  import ask_rx_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic              inbit;
  logic              bit_valid;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic              overrun;
  logic              parity_err;

  modport master (
    input  inbit, bit_valid, word_ready,
    output word_out, word_valid, overrun, parity_err
  );

  modport slave (
    output inbit, bit_valid, word_ready,
    input  word_out, word_valid, overrun, parity_err
  );

endinterface

// File: rtl/word_hold_reg.sv
// One-entry output holding register; loads on the edge ending a load cycle, so dat/vld follow one cycle later.
// Backpressure: a load while full and not drained is dropped, and overrun is raised combinationally in that cycle.
module word_hold_reg
  import ask_rx_pkg::*;
#(
  parameter int W = WORD_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         ready,
  output logic [W-1:0] dat,
  output logic         vld,
  output logic         overrun
);

  assign overrun = load & vld & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat <= '0;
      vld <= 1'b0;
    end else if (load && (!vld || ready)) begin
      dat <= load_dat;
      vld <= 1'b1;
    end else if (vld && ready) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/word_assembler.sv
// Start-bit framed serial-to-parallel assembler; word_valid rises GAP_CYC+1 cycles after the last bit is sampled.
// Backpressure: a completed word finding the output held is dropped with an overrun pulse; WORD_PARITY_EN adds even-parity checking.
module word_assembler
  import ask_rx_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input logic              clk,
  input logic              rst,
  word_assembler_if.master bus
);

  localparam int               IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WORD_W - 2);
  localparam logic [3:0]       GAP_LAST = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  asm_state_t        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [3:0]        gap_cnt, gap_cnt_nxt;
  logic              complete;
  logic [WORD_W-1:0] cmp_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      shreg   <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    shreg_nxt   = shreg;
    gap_cnt_nxt = gap_cnt;
    complete    = 1'b0;
    cmp_word    = shreg;
    unique case (state)
      IDLE: begin
        if (bus.bit_valid && bus.inbit) begin
          shreg_nxt = {1'b1, {(WORD_W-1){1'b0}}};
          idx_nxt   = IDX_TOP;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_valid) begin
          shreg_nxt[idx] = bus.inbit;
          // Index parks at 0 once the frame is full instead of wrapping.
          if (idx == '0) begin
            if (GAP_CYC > 0) begin
              state_nxt   = GAP;
              gap_cnt_nxt = '0;
            end else begin
              state_nxt = IDLE;
              complete  = 1'b1;
              cmp_word  = shreg_nxt;
            end
          end else begin
            idx_nxt = idx - IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
          complete  = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef WORD_PARITY_EN
  // Parity flag travels with the word so it always describes word_out.
  logic [WORD_W:0] hold_dat;

  word_hold_reg #(.W(WORD_W + 1)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (complete),
    .load_dat ({odd_parity(32'(cmp_word)), cmp_word}),
    .ready    (bus.word_ready),
    .dat      (hold_dat),
    .vld      (bus.word_valid),
    .overrun  (bus.overrun)
  );

  assign bus.word_out   = hold_dat[WORD_W-1:0];
  assign bus.parity_err = hold_dat[WORD_W];
`else
  word_hold_reg #(.W(WORD_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (complete),
    .load_dat (cmp_word),
    .ready    (bus.word_ready),
    .dat      (bus.word_out),
    .vld      (bus.word_valid),
    .overrun  (bus.overrun)
  );

  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_word_assembler.sv
// Directed and randomised bench for word_assembler against a frame-level reference model.
module tb_word_assembler;
  import ask_rx_pkg::*;

  localparam int WW  = 12;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  word_assembler_if #(.WORD_W(WW)) bus ();

  word_assembler #(.WORD_W(WW), .GAP_CYC(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          c;
    logic [31:0] w;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] acc_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  bit          collecting;
  int          nbits;
  logic [31:0] acc;
  int          busy_until;
  bit          mv;
  logic [31:0] mw;
  int          first_v, vcount, ovr_count, last_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_parity(input logic [31:0] w);
`ifdef WORD_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] q_head();
    return (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    collecting = 1'b0;
    nbits      = 0;
    acc        = '0;
    busy_until = -1;
    pend_q.delete();
    mv         = 1'b0;
    mw         = '0;
  endtask

  // One clock cycle: drive, check outputs mid-cycle, advance the model.
  task automatic step(input logic b, input logic v, input logic r);
    logic        compl;
    logic [31:0] cw;
    logic        exp_ovr;
    bus.inbit      = b;
    bus.bit_valid  = v;
    bus.word_ready = r;
    @(negedge clk);
    if (cyc > busy_until && v) begin
      if (!collecting) begin
        if (b) begin
          collecting = 1'b1;
          acc        = 32'd1;
          nbits      = 1;
        end
      end else begin
        acc   = (acc << 1) | 32'(b);
        nbits = nbits + 1;
      end
      if (collecting && nbits == WW) begin
        collecting = 1'b0;
        pend_q.push_back('{cyc + GAP, acc});
        busy_until = cyc + GAP;
      end
    end
    compl = (pend_q.size() > 0) && (pend_q[0].c == cyc);
    cw    = compl ? pend_q[0].w : 32'd0;
    if (compl) void'(pend_q.pop_front());
    exp_ovr = compl && mv && !r;

    check("word_valid", 32'(bus.word_valid), 32'(mv));
    check("word_out", 32'(bus.word_out), mw);
    check("overrun", 32'(bus.overrun), 32'(exp_ovr));
    if (mv) check("parity_err", 32'(bus.parity_err), 32'(exp_parity(mw)));

    if (bus.word_valid) begin
      vcount++;
      if (first_v < 0) first_v = cyc;
    end
    if (bus.word_valid && r) acc_q.push_back(32'(bus.word_out));
    if (bus.overrun) ovr_count++;

    if (compl && (!mv || r)) begin
      mv = 1'b1;
      mw = cw;
    end else if (mv && r) begin
      mv = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: back-to-back bits, 1: strobe every other cycle, 2: random gaps and ready
  task automatic send_frame(input logic [31:0] w, input int mode, input logic r);
    logic rr;
    for (int i = WW - 1; i >= 0; i--) begin
      rr = (mode == 2) ? 1'($urandom_range(0, 1)) : r;
      if (mode == 1) begin
        step(1'($urandom_range(0, 1)), 1'b0, rr);
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end
      if (i == 0) last_bit = cyc;
      step(w[i], 1'b1, rr);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.inbit      = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.word_ready = 1'b0;
    #2;
    check("rst_word_valid", 32'(bus.word_valid), 32'd0);
    check("rst_word_out", 32'(bus.word_out), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_parity_err", 32'(bus.parity_err), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = cyc + 2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst            = 1'b1;
    bus.inbit      = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.word_ready = 1'b0;
    model_reset();
    first_v   = -1;
    vcount    = 0;
    ovr_count = 0;
    last_bit  = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Idle line: zeros with strobe never start a frame.
    vcount = 0;
    repeat (100) step(1'b0, 1'b1, 1'b1);
    check("idle_vcount", 32'(vcount), 32'd0);

    // Basic contiguous frame.
    acc_q.delete(); first_v = -1; vcount = 0;
    send_frame(32'hD55, 0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check("basic_count", 32'(acc_q.size()), 32'd1);
    check("basic_word", q_head(), 32'hD55);
    check("basic_latency", 32'(first_v - last_bit), 32'(1 + GAP));
    check("basic_vcycles", 32'(vcount), 32'd1);

    // Sparse strobe with junk on unstrobed cycles.
    acc_q.delete();
    send_frame(32'hD55, 1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check("sparse_count", 32'(acc_q.size()), 32'd1);
    check("sparse_word", q_head(), 32'hD55);

    // Backpressure: second word is dropped.
    acc_q.delete(); ovr_count = 0;
    send_frame(32'hD55, 0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    send_frame(32'h8F0, 0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("bp_overrun_pulses", 32'(ovr_count), 32'd1);
    check("bp_word_held", 32'(bus.word_out), 32'hD55);
    check("bp_valid_held", 32'(bus.word_valid), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("bp_consumed", q_head(), 32'hD55);
    check("bp_valid_drop", 32'(bus.word_valid), 32'd0);
    check("bp_word_after", 32'(bus.word_out), 32'hD55);

    // Randomised frames, strobes and ready.
    for (int f = 0; f < 25; f++) begin
      w = {20'd0, 1'b1, 11'($urandom)};
      send_frame(w, 2, 1'b0);
      repeat (GAP + $urandom_range(0, 3)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    repeat (5) step(1'b0, 1'b0, 1'b1);

    // Reset mid-frame discards the partial word.
    w = 32'hD55;
    for (int i = WW - 1; i > WW - 6; i--) step(w[i], 1'b1, 1'b1);
    @(posedge clk);
    #1;
    do_reset();
    acc_q.delete(); vcount = 0;
    send_frame(32'hD55, 0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check("rstmid_count", 32'(acc_q.size()), 32'd1);
    check("rstmid_word", q_head(), 32'hD55);

`ifdef WORD_PARITY_EN
    send_frame(32'hD55, 0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    check("parity_d55", 32'(bus.parity_err), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    send_frame(32'hD54, 0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    check("parity_d54", 32'(bus.parity_err), 32'd0);
    step(1'b0, 1'b0, 1'b1);
`else
    send_frame(32'hD55, 0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    check("parity_off", 32'(bus.parity_err), 32'd0);
    step(1'b0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
